mdu_iterative: RTL and testbench
================================

MDU_ITERATIVE -- requirements
Module: mdu_iterative

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MUL_STEP, default 1, giving multiplier bits retired per cycle; legal values are 1, 2 and 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port valid, input, 1 bit: the operation request.
REQ-006 Port flush_ex, input, 1 bit: cancels the in-flight or requested operation.
REQ-007 Port funct3, input, 3 bits: RV M-extension op (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-008 Port a, input, XLEN bits: rs1 operand.
REQ-009 Port b, input, XLEN bits: rs2 operand.
REQ-010 Port ready, output, 1 bit: high when idle and able to accept a request.
REQ-011 Port busy, output, 1 bit: high while an operation is in flight.
REQ-012 Port done, output, 1 bit: one-cycle completion pulse.
REQ-013 Port result, output, XLEN bits: the registered result.

Function
REQ-014 The block SHALL implement states IDLE, MUL, DIV and DONE; ready is high only in IDLE, and busy is high only in MUL or DIV.
REQ-015 A request SHALL be accepted when valid=1, ready=1 and flush_ex=0.
- On acceptance, a, b and funct3 are captured into internal registers.
- Input changes after acceptance have no effect.
REQ-016 valid asserted while ready=0 SHALL be ignored, with no queuing.
REQ-017 The multiply path SHALL be used for funct3[2]=0.
- Entry: IDLE to MUL.
- Operation: shift-add, MUL_STEP bits per cycle, over a 2*XLEN-bit product.
- Signedness: operands converted to magnitude per op and the product sign-corrected at the end.
- MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
REQ-018 MUL SHALL last exactly XLEN/MUL_STEP cycles, with done high in cycle T+1+XLEN/MUL_STEP for acceptance in cycle T (XLEN=32, MUL_STEP=1: done at T+33).
REQ-019 The divide path SHALL be used for funct3[2]=1.
- Entry: IDLE to DIV.
- Operation: restoring division, 1 quotient bit per cycle, on magnitudes.
- Sign fixup: quotient negated if operand signs differ (signed ops); remainder takes the sign of the dividend.
- DIV and DIVU return the quotient; REM and REMU return the remainder.
REQ-020 DIV SHALL last exactly XLEN cycles, with done at T+1+XLEN.
REQ-021 Divide-by-zero (b=0) SHALL bypass DIV, going IDLE to DONE with done at T+1.
- Quotient = all ones.
- Remainder = a.
REQ-022 Signed overflow (DIV or REM, a=most-negative, b=-1) SHALL bypass DIV with done at T+1.
- Quotient = a.
- Remainder = 0.
REQ-023 In DONE the block SHALL assert done for exactly one cycle and return to IDLE; a new request may be accepted in the following cycle.
REQ-024 result SHALL update only on the cycle done rises, and hold its value until the next done.
REQ-025 flush_ex=1 in MUL, DIV or DONE SHALL force IDLE on the next edge.
- done is suppressed, including when flush_ex coincides with the would-be done cycle (DONE state).
- result is unchanged.
REQ-026 flush_ex=1 together with valid in IDLE SHALL reject the request.
REQ-027 The internal cycle counter SHALL be sized ceil(log2(XLEN+1)) bits, and no intermediate arithmetic SHALL wrap or truncate before the final XLEN-bit selection.

Reset
REQ-028 rst=1 SHALL, at the next clock edge, force IDLE and the following output values, overriding valid and flush_ex; this holds mid-operation, with the partial result discarded.
- ready = 1
- busy = 0
- done = 0
- result = 0
- counter = 0

Verification
REQ-029 Bench SHALL cover: XLEN=32, MUL_STEP=1, MULH a=0xFFFFFFFF, b=0xFFFFFFFF, accept at T -> done at T+33, result 0x00000000; repeat as MULHU -> result 0xFFFFFFFE.
REQ-030 Bench SHALL cover: MUL_STEP=4, MUL a=7, b=-3 -> done at T+9, result 0xFFFFFFEB.
REQ-031 Bench SHALL cover: DIV a=-7, b=2 -> done at T+33, result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF.
REQ-032 Bench SHALL cover the bypass cases, each with done at T+1:
- DIVU a=5, b=0 -> result 0xFFFFFFFF.
- REM a=0x80000000, b=0xFFFFFFFF -> result 0.
REQ-033 Bench SHALL cover: DIV accepted at T, flush_ex=1 at T+10 -> IDLE and ready=1 at T+11, no done through T+40, result unchanged; a new MUL accepted at T+11 completes normally.
REQ-034 Bench SHALL cover: rst=1 at T+5 of a MUL -> at T+6 ready=1, busy=0, done=0, result=0; valid during busy is ignored (no second done).

Source files
------------

// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV M-extension multiply/divide unit
// Ports: clk, rst (sync, active-high); valid, flush_ex, funct3, a, b (request);
//        ready (idle), busy (in flight), done (1-cycle pulse), result (registered)
module mdu_iterative #(
   parameter int XLEN = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid,
   input  logic            flush_ex,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN + 1);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [2*XLEN-1:0] acc, mc, acc_n, prod;
   logic [XLEN-1:0] mq, rm, q_n, r_n, qv, rv, ma, mb, bypass_res, pend, res_q;
   logic [XLEN:0] tr;
   logic [1:0] op;
   logic neg_q, neg_r, is_mul, sa, sb, na, nb, dz, ovf, bypass, accept, last, ge;
   always_comb begin
      is_mul = !funct3[2];
      sa = is_mul ? funct3[1:0] != 2'b11 : !funct3[0];
      sb = is_mul ? !funct3[1] : !funct3[0];
      na = sa & a[XLEN-1];
      nb = sb & b[XLEN-1];
      ma = na ? -a : a;
      mb = nb ? -b : b;
      dz = b == '0;
      ovf = !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
      bypass = !is_mul && (dz || ovf);
      // divide-by-zero: q=all ones, r=a; signed overflow: q=a, r=0
      bypass_res = dz ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
      accept = state == IDLE && valid && !flush_ex;
      last = cnt == CW'(1);
      // mc holds the multiplicand pre-shifted to the current multiplier digit
      acc_n = acc + mc * {{(2*XLEN-MUL_STEP){1'b0}}, mq[MUL_STEP-1:0]};
      prod = neg_q ? -acc_n : acc_n;
      // restoring division: shift dividend msb into the partial remainder
      tr = {rm, mq[XLEN-1]};
      ge = tr >= {1'b0, mc[XLEN-1:0]};
      r_n = ge ? XLEN'(tr - {1'b0, mc[XLEN-1:0]}) : tr[XLEN-1:0];
      q_n = {mq[XLEN-2:0], ge};
      qv = neg_q ? -q_n : q_n;
      rv = neg_r ? -r_n : r_n;
      state_n = state;
      if (state == IDLE)
         state_n = accept ? (is_mul ? MUL : bypass ? DONE : DIV) : IDLE;
      else if (state == DONE)
         state_n = IDLE;
      else
         state_n = flush_ex ? IDLE : last ? DONE : state;
      ready = state == IDLE;
      busy = state == MUL || state == DIV;
      // a flush in DONE swallows both the pulse and the result commit
      done = state == DONE && !flush_ex;
      result = done ? pend : res_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         acc <= '0;
         mc <= '0;
         mq <= '0;
         rm <= '0;
         op <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         pend <= '0;
         res_q <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            op <= funct3[1:0];
            neg_q <= na ^ nb;
            neg_r <= na;
            acc <= '0;
            rm <= '0;
            mc <= {{XLEN{1'b0}}, is_mul ? ma : mb};
            mq <= is_mul ? mb : ma;
            cnt <= is_mul ? CW'(XLEN / MUL_STEP) : CW'(XLEN);
            pend <= bypass_res;
         end
         if (state == MUL) begin
            acc <= acc_n;
            mc <= mc << MUL_STEP;
            mq <= mq >> MUL_STEP;
            cnt <= cnt - CW'(1);
            if (last) pend <= op == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
         end
         if (state == DIV) begin
            mq <= q_n;
            rm <= r_n;
            cnt <= cnt - CW'(1);
            if (last) pend <= op[1] ? rv : qv;
         end
         if (done) res_q <= pend;
      end
   end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed checks of latency, results, flush and reset for mdu_iterative
module tb_mdu_iterative;
   logic clk = 0, rst = 1, valid = 0, valid4 = 0, flush_ex = 0;
   logic [2:0] funct3 = 0;
   logic [31:0] a = 0, b = 0;
   logic ready, busy, done, ready4, busy4, done4;
   logic [31:0] result, result4;
   int checks = 0, passed = 0;
   always #5 clk = ~clk;
   mdu_iterative #(.XLEN(32), .MUL_STEP(1)) dut (
      .clk(clk), .rst(rst), .valid(valid), .flush_ex(flush_ex), .funct3(funct3),
      .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .result(result)
   );
   mdu_iterative #(.XLEN(32), .MUL_STEP(4)) dut4 (
      .clk(clk), .rst(rst), .valid(valid4), .flush_ex(flush_ex), .funct3(funct3),
      .a(a), .b(b), .ready(ready4), .busy(busy4), .done(done4), .result(result4)
   );
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input int lat, input logic [31:0] res);
      int n;
      check({tag, " ready"}, ready, 1);
      funct3 = f; a = x; b = y; valid = 1;
      @(posedge clk); #1;
      valid = 0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
      n = 1;
      while (!done && n < 100) begin @(posedge clk); #1; n++; end
      check({tag, " latency"}, n, lat);
      check({tag, " result"}, result, res);
      @(posedge clk); #1;
      check({tag, " done pulse"}, done, 0);
      check({tag, " result hold"}, result, res);
   endtask
   initial begin
      int n, nd;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready", ready, 1);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset result", result, 0);
      rst = 0;
      run_op("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000000);
      run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h00000002, 33, 32'hFFFFFFFF);
      run_op("mul", 3'b000, 32'h00010000, 32'h00010003, 33, 32'h00030000);
      run_op("div", 3'b100, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD);
      run_op("rem", 3'b110, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF);
      run_op("remu", 3'b111, 32'd17, 32'd5, 33, 32'd2);
      run_op("divu big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0);
      run_op("divu by 0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
      run_op("rem by 0", 3'b110, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9);
      run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0);
      run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
      funct3 = 3'b000; a = 32'd7; b = 32'hFFFFFFFD; valid4 = 1;
      @(posedge clk); #1;
      valid4 = 0;
      n = 1;
      while (!done4 && n < 100) begin @(posedge clk); #1; n++; end
      check("mul step4 latency", n, 9);
      check("mul step4 result", result4, 32'hFFFFFFEB);
      funct3 = 3'b100; a = 32'd100; b = 32'd7; valid = 1;
      @(posedge clk); #1;
      valid = 0;
      repeat (9) @(posedge clk);
      #1;
      check("flush busy before", busy, 1);
      flush_ex = 1;
      @(posedge clk); #1;
      flush_ex = 0;
      check("flush ready", ready, 1);
      check("flush busy", busy, 0);
      check("flush done", done, 0);
      check("flush result", result, 32'h80000000);
      funct3 = 3'b000; a = 32'd6; b = 32'd7; valid = 1;
      @(posedge clk); #1;
      valid = 0;
      n = 1;
      while (!done && n < 100) begin @(posedge clk); #1; n++; end
      check("post-flush mul latency", n, 33);
      check("post-flush mul result", result, 32'd42);
      @(posedge clk); #1;
      funct3 = 3'b000; a = 32'd3; b = 32'd5; valid = 1;
      @(posedge clk); #1;
      valid = 0;
      repeat (2) @(posedge clk);
      #1;
      funct3 = 3'b101; a = 32'd9; b = 32'd0; valid = 1;
      @(posedge clk); #1;
      valid = 0;
      nd = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) nd++;
         @(posedge clk); #1;
      end
      check("ignored valid dones", nd, 1);
      check("ignored valid result", result, 32'd15);
      funct3 = 3'b000; a = 32'd3; b = 32'd4; valid = 1;
      @(posedge clk); #1;
      valid = 0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("mid rst ready", ready, 1);
      check("mid rst busy", busy, 0);
      check("mid rst done", done, 0);
      check("mid rst result", result, 0);
      run_op("mul after rst", 3'b000, 32'd3, 32'd4, 33, 32'd12);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
